rx_medida_7e1: RTL and testbench
================================

// Module: rx_medida_7e1
// PURPOSE
// - Serial receiver + frame parser for the distance reports sent by the measurement datapath: "XYZ#", 7E1 ASCII.
// - X, Y, Z are BCD digits '0'..'9' (0x30..0x39), sent hundreds first; '#' is 0x23.
// - Rebuilds the 12-bit BCD measure and signals each valid frame with a one-cycle pulse.
// - Sits at the receiving board (or loopback test harness) opposite the tx_serial_7E1 output.
// PARAMETERS
// - CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200 baud)
// - CNT_W         9    width of the bit-timing counter; must hold CLKS_PER_BIT-1
// PORTS
// - clock           in   1   system clock, all logic on rising edge
// - reset           in   1   synchronous, active-high; clears all state and outputs
// - entrada_serial  in   1   asynchronous serial line, idle high
// - medida          out  12  last valid BCD measure {hundreds, tens, units}
// - pronto          out  1   1-cycle pulse: medida just updated
// - erro_paridade   out  1   1-cycle pulse: character with bad even parity
// - erro_formato    out  1   1-cycle pulse: bad stop bit, bad character or bad frame structure
// - db_estado       out  4   debug: {parser state[1:0], rx state[1:0]}
// BEHAVIOUR
// - Reset: medida=0, pronto=0, erro_paridade=0, erro_formato=0, db_estado=0.
//   Reset clears the synchronizer to 1 (idle), the rx FSM to IDLE and the parser to D0.
//   Reset mid-character or mid-frame discards the partial frame; no pulse is generated.
// - Input: 2-FF synchronizer on entrada_serial; all decisions use the synchronized bit.
// - Char framing: start(0), 7 data bits LSB first, even parity, 1 stop(1).
// - Rx FSM:
//   - IDLE: wait for a synchronized 1->0 transition.
//   - START: wait CLKS_PER_BIT/2 (integer division), then resample.
//     If the line is 1, treat it as a glitch: return to IDLE with no pulse. Otherwise go to DATA.
//   - DATA: sample every CLKS_PER_BIT cycles; shift LSB first; 7 samples.
//   - PAR: sample the parity bit.
//   - STOP: sample the stop bit. The character is complete in the cycle this sample is taken.
//     Go to IDLE immediately, so a new start edge is accepted from the next cycle.
// - Char checks, evaluated in the same cycle as the stop sample:
//   - Parity: XOR(data[6:0], parity) must be 0, otherwise the char is a parity error.
//   - Stop: the stop bit must be 1, otherwise the char is a format error.
//   - If both are wrong, both pulses assert in the same cycle.
// - Parser FSM (states D0, D1, D2, HASH, SINC) advances once per completed char:
//   - D0/D1/D2: a digit stores its low nibble into hundreds/tens/units in a temporary register, then advances.
//   - HASH: '#' copies the temporary register to medida and pulses pronto, then goes to D0.
//   - '#' in D0, D1 or D2: erro_formato pulse, go to D0. The '#' itself resynchronizes.
//   - Any other character in D0, D1 or D2: erro_formato pulse, go to SINC.
//   - A digit in HASH (4th digit): erro_formato pulse, go to SINC.
//   - Parity or stop error in any state except SINC: the matching error pulse(s), go to SINC.
//   - SINC: discard chars silently, including bad ones; a clean '#' goes to D0 with no pulse.
// - Latency: pronto and the medida update occur one clock after the stop-bit sample of '#'.
//   Error pulses follow the same one-clock latency.
// - medida changes only on a valid frame; errors never modify it.
// - Pulses are exactly 1 cycle. pronto and the error pulses are mutually exclusive.
// TESTING (CLKS_PER_BIT=8 for simulation)
// - After reset, send "123#": pronto pulses once, 1 clk after the '#' stop sample.
//   Response: medida=12'h123; no errors.
// - Send "1", then '2' with parity flipped, then "3#", then "456#".
//   Response: erro_paridade once at '2'; no pronto for "3#"; medida holds 12'h123.
//   Then pronto with medida=12'h456.
// - Send "12#": erro_formato at '#'. Then "789#": pronto with medida=12'h789.
// - Send "1A3#": erro_formato at 'A'; the trailing '#' resyncs silently.
//   Then "050#": medida=12'h050.
// - Pulse line low for 3 clks while idle: no char, no pulses.
//   Stop bit forced 0 on the '#' of "999#": erro_formato; medida unchanged.
// - Assert reset during the 2nd char of "321#": all outputs 0.
//   Then "654#": medida=12'h654 with a single pronto.

Source files
------------

// File: rtl/rx_medida_7e1.sv
// 7E1 serial receiver and "XYZ#" frame parser: rebuilds a 3-digit BCD measure
// and flags each valid frame, parity error and format error with 1-cycle pulses.
module rx_medida_7e1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_t;
    typedef enum logic [2:0] {P_D0, P_D1, P_D2, P_HASH, P_SINC} ps_t;

    logic [1:0] sync_q;
    logic       rx_s, rx_prev;
    assign rx_s = sync_q[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], entrada_serial};
            rx_prev <= rx_s;
        end
    end

    rx_t              rx_state, rx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [6:0]       shreg, sh_next;
    logic             par_bit, par_next;
    logic             char_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_next;
            shreg    <= sh_next;
            par_bit  <= par_next;
        end
    end

    always_comb begin
        rx_next   = rx_state;
        cnt_next  = cnt + 1'b1;
        bit_next  = bit_idx;
        sh_next   = shreg;
        par_next  = par_bit;
        char_done = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_s) rx_next = RX_START;
            end
            RX_START: if (cnt == HALF_LAST) begin
                // a line already back high at mid-start is a glitch, not a char
                cnt_next = '0;
                bit_next = '0;
                rx_next  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt == LAST) begin
                cnt_next = '0;
                sh_next  = {rx_s, shreg[6:1]};
                bit_next = bit_idx + 1'b1;
                if (bit_idx == 3'd6) rx_next = RX_PAR;
            end
            RX_PAR: if (cnt == LAST) begin
                cnt_next = '0;
                par_next = rx_s;
                rx_next  = RX_STOP;
            end
            RX_STOP: if (cnt == LAST) begin
                cnt_next  = '0;
                char_done = 1'b1;
                rx_next   = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // char checks are valid only in the char_done cycle (stop sample = rx_s)
    logic par_err, stop_err, is_digit, is_hash;
    assign par_err  = ^{shreg, par_bit};
    assign stop_err = !rx_s;
    assign is_digit = (shreg >= 7'h30) && (shreg <= 7'h39);
    assign is_hash  = (shreg == 7'h23);

    ps_t         p_state, p_next;
    logic [11:0] tmp, tmp_next, med_next;
    logic        pr_next, ep_next, ef_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            p_state       <= P_D0;
            tmp           <= '0;
            medida        <= '0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_formato  <= 1'b0;
        end else begin
            p_state       <= p_next;
            tmp           <= tmp_next;
            medida        <= med_next;
            pronto        <= pr_next;
            erro_paridade <= ep_next;
            erro_formato  <= ef_next;
        end
    end

    always_comb begin
        p_next   = p_state;
        tmp_next = tmp;
        med_next = medida;
        pr_next  = 1'b0;
        ep_next  = 1'b0;
        ef_next  = 1'b0;
        if (char_done) begin
            if (p_state == P_SINC) begin
                if (!par_err && !stop_err && is_hash) p_next = P_D0;
            end else if (par_err || stop_err) begin
                ep_next = par_err;
                ef_next = stop_err;
                p_next  = P_SINC;
            end else if (is_digit) begin
                case (p_state)
                    P_D0: begin tmp_next[11:8] = shreg[3:0]; p_next = P_D1; end
                    P_D1: begin tmp_next[7:4]  = shreg[3:0]; p_next = P_D2; end
                    P_D2: begin tmp_next[3:0]  = shreg[3:0]; p_next = P_HASH; end
                    default: begin ef_next = 1'b1; p_next = P_SINC; end
                endcase
            end else if (is_hash) begin
                // an early '#' still marks a frame boundary, so restart at D0
                if (p_state == P_HASH) begin
                    pr_next  = 1'b1;
                    med_next = tmp;
                end else begin
                    ef_next = 1'b1;
                end
                p_next = P_D0;
            end else begin
                ef_next = 1'b1;
                p_next  = P_SINC;
            end
        end
    end

    // SINC and STOP alias to 0 in the 2-bit debug view
    assign db_estado = {p_state[1:0], rx_state[1:0]};
endmodule

// File: tb/tb_rx_medida_7e1.sv
// Directed bench for rx_medida_7e1: drives 7E1 chars, scoreboards expected pulses.
module tb_rx_medida_7e1;
    localparam int CPB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] medida;
    logic        pronto, erro_paridade, erro_formato;
    logic [3:0]  db_estado;

    rx_medida_7e1 #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
        .medida(medida), .pronto(pronto), .erro_paridade(erro_paridade),
        .erro_formato(erro_formato), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  code;   // {pronto, erro_paridade, erro_formato}
        logic [11:0] med;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  stop_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [2:0] code, input logic [11:0] med);
        ev_t e;
        e.code = code;
        e.med  = med;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        entrada_serial = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_char(input logic [6:0] c, input bit flip_par, input bit bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(c[i]);
        drive_bit((^c) ^ flip_par);
        stop_cyc = cyc;
        drive_bit(!bad_stop);
        drive_bit(1'b1);
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0], 1'b0, 1'b0);
        end
    endtask

    task automatic settle(input string tag);
        repeat (2 * CPB) @(negedge clock);
        check(tag, sb.size(), 0);
    endtask

    // every pulse cycle must match the next scoreboard entry
    always @(negedge clock) begin
        ev_t        e;
        logic [2:0] code;
        int         ofs;
        code = {pronto, erro_paridade, erro_formato};
        if (code != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, code}, 32'd0);
            end else begin
                e   = sb.pop_front();
                ofs = cyc - stop_cyc;
                check("pulse_kind", {29'd0, code}, {29'd0, e.code});
                if (pronto) check("medida_on_pronto", {20'd0, medida}, {20'd0, e.med});
                check("pulse_latency", {31'd0, (ofs >= CPB / 2) && (ofs <= CPB + 2)}, 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_medida", {20'd0, medida}, 32'd0);
        check("rst_pulses", {29'd0, pronto, erro_paridade, erro_formato}, 32'd0);
        check("rst_db", {28'd0, db_estado}, 32'd0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);

        push_ev(3'b100, 12'h123);
        send_str("123#");
        settle("drain_123");
        check("medida_123", {20'd0, medida}, 32'h123);

        push_ev(3'b010, 12'h000);
        send_str("1");
        send_char(7'h32, 1'b1, 1'b0);
        send_str("3#");
        settle("drain_parity");
        check("medida_hold_parity", {20'd0, medida}, 32'h123);
        push_ev(3'b100, 12'h456);
        send_str("456#");
        settle("drain_456");

        push_ev(3'b001, 12'h000);
        send_str("12#");
        push_ev(3'b100, 12'h789);
        send_str("789#");
        settle("drain_789");

        push_ev(3'b001, 12'h000);
        send_str("1A3#");
        settle("drain_bad_char");
        check("medida_hold_fmt", {20'd0, medida}, 32'h789);
        push_ev(3'b100, 12'h050);
        send_str("050#");
        settle("drain_050");

        entrada_serial = 1'b0;
        repeat (3) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("glitch_no_event", sb.size(), 0);
        check("glitch_idle_db", {28'd0, db_estado}, 32'd0);

        push_ev(3'b001, 12'h000);
        send_str("999");
        send_char(7'h23, 1'b0, 1'b1);
        settle("drain_bad_stop");
        check("medida_hold_stop", {20'd0, medida}, 32'h050);

        send_str("3");
        drive_bit(1'b0);
        drive_bit(1'b0);
        entrada_serial = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst_medida", {20'd0, medida}, 32'd0);
        check("midrst_pulses", {29'd0, pronto, erro_paridade, erro_formato}, 32'd0);
        check("midrst_db", {28'd0, db_estado}, 32'd0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);

        push_ev(3'b100, 12'h654);
        send_str("654#");
        settle("drain_654");
        check("medida_654", {20'd0, medida}, 32'h654);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
